// File: rtl/csr_access_unit_if.sv
// Bundle of request, CSR-file and result signals for csr_access_unit.
// The master side issues requests and models the CSR file; the slave side is the unit.
interface csr_access_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csr_number;
    logic [31:0] rs1_value;
    logic [4:0]  rs1_field;
    logic [31:0] csr_read_value;
    logic [11:0] address;
    logic [31:0] write_value;
    logic        write_enable;
    logic        busy;
    logic        done;
    logic [31:0] rd_value;
    logic        illegal;

    modport master (
        output start, funct3, csr_number, rs1_value, rs1_field, csr_read_value,
        input  address, write_value, write_enable, busy, done, rd_value, illegal
    );

    modport slave (
        input  start, funct3, csr_number, rs1_value, rs1_field, csr_read_value,
        output address, write_value, write_enable, busy, done, rd_value, illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr read-modify-write: IDLE -> READ -> WRITE -> DONE.
// Define CSR_ACCESS_READ_ONLY_CHECK_EN to trap writes to read-only CSRs (address[11:10] == 2'b11).
module csr_access_unit (
    input  logic              clock,
    input  logic              reset,
    csr_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  funct3_reg;
    logic [11:0] csr_number_reg;
    logic [4:0]  rs1_field_reg;
    logic [31:0] operand_reg;
    logic [31:0] rd_value_reg;

    logic        bad_funct3;
    logic        suppress_write;
    logic        read_only_hit;
    logic        illegal_access;
    logic [31:0] new_value;

    logic [11:0] address;
    logic [31:0] write_value;
    logic        write_enable;
    logic        busy;
    logic        done;
    logic        illegal;

    // funct3[1:0] == 00 covers both reserved encodings (000 and 100).
    assign bad_funct3     = (funct3_reg[1:0] == 2'b00);
    // Set/clear forms with x0/zimm=0 are pure reads.
    assign suppress_write = funct3_reg[1] && (rs1_field_reg == 5'd0);

`ifdef CSR_ACCESS_READ_ONLY_CHECK_EN
    assign read_only_hit  = (csr_number_reg[11:10] == 2'b11) && !suppress_write;
`else
    assign read_only_hit  = 1'b0;
`endif

    assign illegal_access = bad_funct3 || read_only_hit;

    always_comb begin
        new_value = '0;
        case (funct3_reg[1:0])
            2'b01:   new_value = operand_reg;
            2'b10:   new_value = rd_value_reg | operand_reg;
            2'b11:   new_value = rd_value_reg & ~operand_reg;
            default: new_value = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            funct3_reg     <= '0;
            csr_number_reg <= '0;
            rs1_field_reg  <= '0;
            operand_reg    <= '0;
            rd_value_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.start) begin
                funct3_reg     <= bus.funct3;
                csr_number_reg <= bus.csr_number;
                rs1_field_reg  <= bus.rs1_field;
                operand_reg    <= bus.funct3[2] ? {27'd0, bus.rs1_field} : bus.rs1_value;
            end
            if (state_reg == READ) begin
                rd_value_reg <= bad_funct3 ? 32'd0 : bus.csr_read_value;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        address      = '0;
        write_value  = '0;
        write_enable = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        illegal      = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_next = READ;
            end
            READ: begin
                address    = csr_number_reg;
                state_next = WRITE;
            end
            WRITE: begin
                address      = csr_number_reg;
                write_value  = new_value;
                write_enable = !suppress_write && !illegal_access;
                state_next   = DONE;
            end
            DONE: begin
                address    = csr_number_reg;
                done       = 1'b1;
                illegal    = illegal_access;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.address      = address;
    assign bus.write_value  = write_value;
    assign bus.write_enable = write_enable;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.rd_value     = rd_value_reg;
    assign bus.illegal      = illegal;
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit; one task per scenario.
module tb_csr_access_unit;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one request; observes 8 cycles sampled on falling edges (c=1 READ, c=2 WRITE, c=3 DONE).
    task automatic run_op(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] rs1v,
                          input logic [4:0] field, input logic [31:0] old,
                          output int we_cnt, output logic [31:0] wv_write, output int done_cyc,
                          output int done_cnt, output logic ill_done, output logic [31:0] rd_done,
                          output logic [11:0] addr_write, output logic [11:0] addr_idle);
        we_cnt = 0; wv_write = '0; done_cyc = -1; done_cnt = 0; ill_done = 1'b0;
        rd_done = '0; addr_write = '0; addr_idle = '1;
        @(negedge clock);
        bus.funct3 = f3; bus.csr_number = csr; bus.rs1_value = rs1v;
        bus.rs1_field = field; bus.csr_read_value = old; bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.write_enable === 1'b1) we_cnt++;
            if (c == 2) begin wv_write = bus.write_value; addr_write = bus.address; end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; ill_done = bus.illegal; rd_done = bus.rd_value; end
            end
            if (c == 8) addr_idle = bus.address;
        end
        $display("op f3=%0b csr=%03h rs1=%08h field=%0d old=%08h -> we=%0d wv=%08h done@%0d ill=%0b rd=%08h",
                 f3, csr, rs1v, field, old, we_cnt, wv_write, done_cyc, ill_done, rd_done);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.illegal !== 1'b0 || bus.write_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b ill=%b we=%b want 0000", bus.busy, bus.done, bus.illegal, bus.write_enable); end
        n_cmp++; if (bus.address !== 12'h0 || bus.write_value !== 32'h0 || bus.rd_value !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wv=%h rd=%h want 0", bus.address, bus.write_value, bus.rd_value); end
    endtask

    task automatic test_csrrw();
        int we, dc, dn; logic ill; logic [31:0] wv, rd; logic [11:0] aw, ai;
        run_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5, 32'h0000_1234, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL rw_rd: got %h want 00001234", rd); end
        n_cmp++; if (we !== 1) begin n_fail++; $display("FAIL rw_we_count: got %0d want 1", we); end
        n_cmp++; if (wv !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_wv: got %h want deadbeef", wv); end
        n_cmp++; if (dc !== 3 || dn !== 1) begin n_fail++; $display("FAIL rw_done: at %0d count %0d want at 3 count 1", dc, dn); end
        n_cmp++; if (aw !== 12'h340 || ai !== 12'h000) begin n_fail++; $display("FAIL rw_addr: write %h idle %h want 340 000", aw, ai); end
        n_cmp++; if (ill !== 1'b0) begin n_fail++; $display("FAIL rw_illegal: got %b want 0", ill); end
    endtask

    task automatic test_csrrs();
        int we, dc, dn; logic ill; logic [31:0] wv, rd; logic [11:0] aw, ai;
        run_op(3'b010, 12'h300, 32'h0000_0008, 5'd3, 32'h0000_1800, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (wv !== 32'h0000_1808 || we !== 1) begin n_fail++; $display("FAIL rs_write: wv %h we %0d want 00001808 1", wv, we); end
        run_op(3'b010, 12'h300, 32'h0000_0008, 5'd0, 32'h0000_1800, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (we !== 0) begin n_fail++; $display("FAIL rs_x0_we: got %0d want 0", we); end
        n_cmp++; if (rd !== 32'h0000_1800 || ill !== 1'b0) begin n_fail++; $display("FAIL rs_x0_rd: rd %h ill %b want 00001800 0", rd, ill); end
    endtask

    task automatic test_csrrci();
        int we, dc, dn; logic ill; logic [31:0] wv, rd; logic [11:0] aw, ai;
        run_op(3'b111, 12'h304, 32'hFFFF_FFFF, 5'd8, 32'h0000_0888, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (wv !== 32'h0000_0880 || we !== 1) begin n_fail++; $display("FAIL rci_write: wv %h we %0d want 00000880 1", wv, we); end
        n_cmp++; if (rd !== 32'h0000_0888) begin n_fail++; $display("FAIL rci_rd: got %h want 00000888", rd); end
        run_op(3'b110, 12'h304, 32'h0000_0000, 5'd3, 32'h0000_0880, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (wv !== 32'h0000_0883 || we !== 1) begin n_fail++; $display("FAIL rsi_write: wv %h we %0d want 00000883 1", wv, we); end
    endtask

    task automatic test_read_only();
        int we, dc, dn; logic ill; logic [31:0] wv, rd; logic [11:0] aw, ai;
        run_op(3'b001, 12'hF14, 32'h0000_0055, 5'd7, 32'h0000_0ABC, we, wv, dc, dn, ill, rd, aw, ai);
`ifdef CSR_ACCESS_READ_ONLY_CHECK_EN
        n_cmp++; if (ill !== 1'b1 || we !== 0) begin n_fail++; $display("FAIL ro_rw: ill %b we %0d want 1 0", ill, we); end
`else
        n_cmp++; if (ill !== 1'b0 || we !== 1) begin n_fail++; $display("FAIL ro_rw: ill %b we %0d want 0 1", ill, we); end
`endif
        n_cmp++; if (rd !== 32'h0000_0ABC) begin n_fail++; $display("FAIL ro_rd: got %h want 00000abc", rd); end
        run_op(3'b010, 12'hF14, 32'h0000_0055, 5'd0, 32'h0000_0ABC, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (ill !== 1'b0 || we !== 0) begin n_fail++; $display("FAIL ro_rs_x0: ill %b we %0d want 0 0", ill, we); end
    endtask

    task automatic test_illegal_funct3();
        int we, dc, dn; logic ill; logic [31:0] wv, rd; logic [11:0] aw, ai;
        run_op(3'b000, 12'h340, 32'h1234_5678, 5'd9, 32'h0000_7777, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (ill !== 1'b1 || we !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL ill_000: ill %b we %0d rd %h want 1 0 0", ill, we, rd); end
        run_op(3'b100, 12'h340, 32'h1234_5678, 5'd9, 32'h0000_7777, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (ill !== 1'b1 || we !== 0 || rd !== 32'h0) begin n_fail++; $display("FAIL ill_100: ill %b we %0d rd %h want 1 0 0", ill, we, rd); end
    endtask

    // start held high: accepted requests must complete 4 cycles apart, illegal low outside DONE.
    task automatic test_back_to_back();
        int d0, d1, dn, ill_bad;
        d0 = -1; d1 = -1; dn = 0; ill_bad = 0;
        @(negedge clock);
        bus.funct3 = 3'b001; bus.csr_number = 12'h340; bus.rs1_value = 32'h0000_00AA;
        bus.rs1_field = 5'd1; bus.csr_read_value = 32'h0; bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 5) bus.start = 1'b0;
            if (bus.done === 1'b1) begin dn++; if (d0 < 0) d0 = c; else d1 = c; end
            if (bus.done !== 1'b1 && bus.illegal !== 1'b0) ill_bad++;
        end
        $display("back_to_back: done at %0d and %0d (count %0d)", d0, d1, dn);
        n_cmp++; if (d0 !== 3 || d1 !== 7 || dn !== 2) begin n_fail++; $display("FAIL b2b_done: %0d %0d n=%0d want 3 7 n=2", d0, d1, dn); end
        n_cmp++; if (ill_bad !== 0) begin n_fail++; $display("FAIL b2b_illegal_outside_done: got %0d want 0", ill_bad); end
    endtask

    task automatic test_busy_ignore();
        int we, dn, busy_idle; logic [31:0] wv; logic [11:0] aw;
        we = 0; dn = 0; busy_idle = 0; wv = '0; aw = '0;
        @(negedge clock);
        bus.funct3 = 3'b001; bus.csr_number = 12'h340; bus.rs1_value = 32'h1111_1111;
        bus.rs1_field = 5'd1; bus.csr_read_value = 32'h0; bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            bus.start = (c == 1 || c == 2);
            if (c == 1) begin bus.csr_number = 12'h300; bus.rs1_value = 32'h2222_2222; end
            if (bus.write_enable === 1'b1) we++;
            if (c == 2) begin wv = bus.write_value; aw = bus.address; end
            if (bus.done === 1'b1) dn++;
            if (c >= 4 && bus.busy !== 1'b0) busy_idle++;
        end
        $display("busy_ignore: we=%0d wv=%08h addr=%03h done=%0d", we, wv, aw, dn);
        n_cmp++; if (wv !== 32'h1111_1111 || aw !== 12'h340) begin n_fail++; $display("FAIL busy_wv: %h %h want 11111111 340", wv, aw); end
        n_cmp++; if (we !== 1 || dn !== 1 || busy_idle !== 0) begin n_fail++; $display("FAIL busy_count: we %0d done %0d late_busy %0d want 1 1 0", we, dn, busy_idle); end
    endtask

    task automatic test_reset_in_write();
        int we, dc, dn; logic ill; logic [31:0] wv, rd; logic [11:0] aw, ai;
        @(negedge clock);
        bus.funct3 = 3'b001; bus.csr_number = 12'h340; bus.rs1_value = 32'h5555_AAAA;
        bus.rs1_field = 5'd2; bus.csr_read_value = 32'h0000_4321; bus.start = 1'b1;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        n_cmp++; if (bus.write_enable !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %b want 1", bus.write_enable); end
        #2 reset = 1'b1;
        #1;
        $display("reset_in_write: we=%b busy=%b done=%b addr=%h wv=%h rd=%h", bus.write_enable, bus.busy, bus.done, bus.address, bus.write_value, bus.rd_value);
        n_cmp++; if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: we %b busy %b done %b ill %b want 0", bus.write_enable, bus.busy, bus.done, bus.illegal); end
        n_cmp++; if (bus.address !== 12'h0 || bus.write_value !== 32'h0 || bus.rd_value !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_data: addr %h wv %h rd %h want 0", bus.address, bus.write_value, bus.rd_value); end
        @(negedge clock); reset = 1'b0;
        run_op(3'b011, 12'h304, 32'h0000_000F, 5'd4, 32'h0000_00FF, we, wv, dc, dn, ill, rd, aw, ai);
        n_cmp++; if (wv !== 32'h0000_00F0 || we !== 1 || dc !== 3 || rd !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL rst_after: wv %h we %0d done@%0d rd %h want 000000f0 1 3 000000ff", wv, we, dc, rd); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.funct3 = '0; bus.csr_number = '0;
        bus.rs1_value = '0; bus.rs1_field = '0; bus.csr_read_value = '0;
        @(negedge clock); @(negedge clock);
        test_reset();
        reset = 1'b0;
        test_csrrw();
        test_csrrs();
        test_csrrci();
        test_read_only();
        test_illegal_funct3();
        test_back_to_back();
        test_busy_ignore();
        test_reset_in_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
